// File: rtl/ddr_rx_deser_ctrl.sv
// ddr_rx_deser_ctrl: deserialises a 2-bit DDR stream into DATA_WIDTH-bit words.
// A training pattern is searched at bit offsets 0 and 1. Once it has been seen
// LOCK_COUNT times in a row at a fixed word boundary, the receiver locks and
// pushes every following word into a 2-entry output FIFO.
// Optional feature: define DDR_RX_DESER_STATS_EN to add the word_cnt output,
// which counts accepted transfers.
// state_dbg encoding: 0 = IDLE, 1 = TRAIN, 2 = LOCKED.
// Handshake: data_vld is high while the FIFO holds a word and data_out shows
// the head entry. A word is transferred on every rising edge where
// data_vld & data_rd are both high. data_out does not change while data_vld=1
// and data_rd=0.
module ddr_rx_deser_ctrl #(
  parameter int                    DATA_WIDTH    = 8,
  parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = 8'hA5,
  parameter int                    LOCK_COUNT    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            ddr_in,
  input  logic                  train_req,
  output logic                  locked,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_vld,
  input  logic                  data_rd,
  output logic                  overflow,
`ifdef DDR_RX_DESER_STATS_EN
  output logic [15:0]           word_cnt,
`endif
  output logic [1:0]            state_dbg
);

  localparam int HALF = DATA_WIDTH / 2;
  localparam int PW   = (HALF > 1) ? $clog2(HALF) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_TRAIN  = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  state_t                  state, state_n;
  logic                    searching, searching_n;
  logic                    offset, offset_n;
  logic [3:0]              hit_cnt, hit_n;
  logic [PW-1:0]           phase, phase_n;
  logic [2*DATA_WIDTH-1:0] sr;
  logic                    write_due;

  logic [DATA_WIDTH-1:0]   mem [2];
  logic                    wr_ptr, rd_ptr;
  logic [1:0]              count;
  logic                    pop, do_write;

  logic [DATA_WIDTH-1:0]   w0, w1, word_sel;
  logic                    wrap, w0_hit, w1_hit;

  // Only the lower W+1 bits form candidate words; the upper part is history.
  logic                    unused_sr_msbs;
  assign unused_sr_msbs = ^sr[2*DATA_WIDTH-1:DATA_WIDTH+1];

  assign w0       = sr[DATA_WIDTH-1:0];
  assign w1       = sr[DATA_WIDTH:1];
  assign word_sel = offset ? w1 : w0;
  assign w0_hit   = (w0 == TRAIN_PATTERN);
  assign w1_hit   = (w1 == TRAIN_PATTERN);
  assign wrap     = (phase == PW'(HALF - 1));

  assign data_vld  = (count != 2'd0);
  assign data_out  = data_vld ? mem[rd_ptr] : '0;
  assign locked    = (state == S_LOCKED);
  assign state_dbg = state;
  assign pop       = data_vld & data_rd;
  assign do_write  = write_due & ((count < 2'd2) | pop);

  // Shift register: two new bits per cycle, newest at the LSB.
  always_ff @(posedge clk) begin
    if (rst) sr <= '0;
    else     sr <= {sr[2*DATA_WIDTH-3:0], ddr_in[1], ddr_in[0]};
  end

  // Alignment FSM: next state, search/verify bookkeeping and write request.
  always_comb begin
    state_n     = state;
    searching_n = searching;
    offset_n    = offset;
    hit_n       = hit_cnt;
    phase_n     = wrap ? '0 : phase + PW'(1);
    write_due   = 1'b0;
    case (state)
      S_IDLE: begin
        if (train_req) begin
          state_n     = S_TRAIN;
          searching_n = 1'b1;
          hit_n       = 4'd0;
          phase_n     = '0;
        end
      end
      S_TRAIN: begin
        if (train_req) begin
          searching_n = 1'b1;
          hit_n       = 4'd0;
          phase_n     = '0;
        end else if (searching) begin
          if (w0_hit || w1_hit) begin
            offset_n    = ~w0_hit;
            hit_n       = 4'd1;
            phase_n     = '0;
            searching_n = 1'b0;
            if (LOCK_COUNT == 1) state_n = S_LOCKED;
          end
        end else if (wrap) begin
          if (word_sel == TRAIN_PATTERN) begin
            hit_n = hit_cnt + 4'd1;
            if (hit_cnt + 4'd1 == 4'(LOCK_COUNT)) state_n = S_LOCKED;
          end else begin
            hit_n       = 4'd0;
            searching_n = 1'b1;
          end
        end
      end
      S_LOCKED: begin
        if (train_req) begin
          state_n     = S_TRAIN;
          searching_n = 1'b1;
          hit_n       = 4'd0;
          phase_n     = '0;
        end else if (wrap) begin
          write_due = 1'b1;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // FSM state and alignment registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      searching <= 1'b1;
      offset    <= 1'b0;
      hit_cnt   <= 4'd0;
      phase     <= '0;
    end else begin
      state     <= state_n;
      searching <= searching_n;
      offset    <= offset_n;
      hit_cnt   <= hit_n;
      phase     <= phase_n;
    end
  end

  // Output FIFO; a retrain flush takes priority over any write or pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      overflow <= 1'b0;
    end else if (train_req) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      overflow <= 1'b0;
    end else begin
      if (pop) rd_ptr <= ~rd_ptr;
      if (do_write) begin
        mem[wr_ptr] <= word_sel;
        wr_ptr      <= ~wr_ptr;
      end
      count <= count + {1'b0, do_write} - {1'b0, pop};
      if (write_due && !do_write) overflow <= 1'b1;
    end
  end

`ifdef DDR_RX_DESER_STATS_EN
  // Saturating count of accepted transfers.
  always_ff @(posedge clk) begin
    if (rst || train_req)              word_cnt <= 16'd0;
    else if (pop && word_cnt != 16'hFFFF) word_cnt <= word_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_ddr_rx_deser_ctrl.sv
// Bench for ddr_rx_deser_ctrl: directed DDR bit streams, a bit-history model
// checked every cycle, plus hand-computed literal expectations.
module tb_ddr_rx_deser_ctrl;

  localparam int W    = 8;
  localparam int HALF = W / 2;
  localparam int LC   = 4;
  localparam logic [W-1:0] PAT = 8'hA5;
  localparam int M_IDLE = 0, M_TRAIN = 1, M_LOCKED = 2;

  logic         clk, rst, train_req, data_rd;
  logic [1:0]   ddr_in;
  logic         locked, data_vld, overflow;
  logic [W-1:0] data_out;
  logic [1:0]   state_dbg;
`ifdef DDR_RX_DESER_STATS_EN
  logic [15:0]  word_cnt;
`endif

  int checks = 0;
  int errors = 0;

  ddr_rx_deser_ctrl #(.DATA_WIDTH(W), .TRAIN_PATTERN(PAT), .LOCK_COUNT(LC)) dut (
    .clk(clk), .rst(rst), .ddr_in(ddr_in), .train_req(train_req),
    .locked(locked), .data_out(data_out), .data_vld(data_vld),
    .data_rd(data_rd), .overflow(overflow),
`ifdef DDR_RX_DESER_STATS_EN
    .word_cnt(word_cnt),
`endif
    .state_dbg(state_dbg)
  );

  // Clock and reset defaults
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: bit history, alignment bookkeeping, expected queue
  bit           hist[$];
  logic [W-1:0] exp_q[$];
  int           m_state, m_off, m_hits, m_since, m_cnt;
  bit           m_search, m_ovf;

  task automatic reset_model();
    hist.delete();
    for (int i = 0; i < 2 * W; i++) hist.push_back(1'b0);
    exp_q.delete();
    m_state = M_IDLE; m_search = 1'b1; m_off = 0; m_hits = 0;
    m_since = 0; m_ovf = 1'b0; m_cnt = 0;
  endtask

  // Word ending 'skip' bits before the newest received bit, oldest bit as MSB.
  function automatic logic [W-1:0] hist_word(input int skip);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = hist[hist.size() - 1 - skip - i];
    return r;
  endfunction

  task automatic model_step();
    logic [W-1:0] w0, w1, ws;
    bit pop;
    if (rst) begin
      reset_model();
      return;
    end
    w0  = hist_word(0);
    w1  = hist_word(1);
    pop = (exp_q.size() > 0) && data_rd;
    if (train_req) begin
      m_state = M_TRAIN; m_search = 1'b1; m_hits = 0; m_since = 0;
      exp_q.delete(); m_ovf = 1'b0; m_cnt = 0;
    end else begin
      if (pop) begin
        void'(exp_q.pop_front());
        if (m_cnt < 65535) m_cnt++;
      end
      if (m_state == M_TRAIN && m_search) begin
        if (w0 == PAT || w1 == PAT) begin
          m_off = (w0 == PAT) ? 0 : 1;
          m_hits = 1; m_since = 0; m_search = 1'b0;
          if (m_hits == LC) m_state = M_LOCKED;
        end
      end else if (m_state != M_IDLE) begin
        m_since++;
        if (m_since == HALF) begin
          m_since = 0;
          ws = (m_off == 1) ? w1 : w0;
          if (m_state == M_TRAIN) begin
            if (ws == PAT) begin
              m_hits++;
              if (m_hits == LC) m_state = M_LOCKED;
            end else begin
              m_hits = 0; m_search = 1'b1;
            end
          end else if (exp_q.size() < 2) begin
            exp_q.push_back(ws);
          end else begin
            m_ovf = 1'b1;
          end
        end
      end
    end
    hist.push_back(ddr_in[1]);
    hist.push_back(ddr_in[0]);
    while (hist.size() > 2 * W) void'(hist.pop_front());
  endtask

  // Scoreboard: advance the model on each edge, then compare all outputs
  initial begin
    reset_model();
    forever begin
      @(posedge clk);
      #1;
      model_step();
      check("locked", 32'(locked), 32'(m_state == M_LOCKED));
      check("data_vld", 32'(data_vld), 32'(exp_q.size() > 0));
      check("data_out", 32'(data_out), (exp_q.size() > 0) ? 32'(exp_q[0]) : 32'd0);
      check("overflow", 32'(overflow), 32'(m_ovf));
`ifdef DDR_RX_DESER_STATS_EN
      check("word_cnt", 32'(word_cnt), 32'(m_cnt));
`endif
    end
  end

  // Driver: transmit bit queue, two bits per cycle, older bit on ddr_in[1]
  bit tx_q[$];

  task automatic push_word(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) tx_q.push_back(w[i]);
  endtask

  task automatic step();
    logic b1, b0;
    b1 = 1'b0; b0 = 1'b0;
    if (tx_q.size() > 0) b1 = tx_q.pop_front();
    if (tx_q.size() > 0) b0 = tx_q.pop_front();
    ddr_in = {b1, b0};
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic train_pulse();
    train_req = 1'b1;
    step();
    train_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1; train_req = 1'b0; data_rd = 1'b0; ddr_in = 2'b00;
    repeat (3) @(negedge clk);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_vld", 32'(data_vld), 32'd0);
    check("rst_out", 32'(data_out), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    rst = 1'b0;

    // Offset 0 lock, then 8'h3C output with two-cycle latency
    train_pulse();
    for (int i = 0; i < 4; i++) push_word(PAT);
    push_word(8'h3C);
    run(16);
    check("a_locked_pre", 32'(locked), 32'd0);
    check("a_vld_train", 32'(data_vld), 32'd0);
    run(1);
    check("a_locked", 32'(locked), 32'd1);
    check("a_vld_lock", 32'(data_vld), 32'd0);
    run(3);
    check("a_vld_pre", 32'(data_vld), 32'd0);
    run(1);
    check("a_vld", 32'(data_vld), 32'd1);
    check("a_out", 32'(data_out), 32'h3C);
    data_rd = 1'b1;
    run(8);
    data_rd = 1'b0;

    // Offset 1 lock: one leading pad bit shifts every word by one
    train_pulse();
    check("b_state_train", 32'(state_dbg), 32'd1);
    tx_q.push_back(1'b0);
    for (int i = 0; i < 4; i++) push_word(PAT);
    push_word(8'h3C);
    run(17);
    check("b_locked_pre", 32'(locked), 32'd0);
    run(1);
    check("b_locked", 32'(locked), 32'd1);
    run(3);
    check("b_vld_pre", 32'(data_vld), 32'd0);
    run(1);
    check("b_vld", 32'(data_vld), 32'd1);
    check("b_out", 32'(data_out), 32'h3C);

    // Corrupted third pattern, relock, then overflow and full-with-pop
    train_pulse();
    push_word(PAT); push_word(PAT); push_word(8'hA4);
    for (int i = 0; i < 4; i++) push_word(PAT);
    push_word(8'h11); push_word(8'h22); push_word(8'h33);
    push_word(8'h44); push_word(8'h55); push_word(8'h66);
    run(28);
    check("c_locked_pre", 32'(locked), 32'd0);
    run(1);
    check("c_locked", 32'(locked), 32'd1);
    run(11);
    check("c_ovf_pre", 32'(overflow), 32'd0);
    run(1);
    check("c_ovf", 32'(overflow), 32'd1);
    check("c_head11", 32'(data_out), 32'h11);
    data_rd = 1'b1;
    run(1);
    check("c_head22", 32'(data_out), 32'h22);
    run(1);
    check("c_empty", 32'(data_vld), 32'd0);
    data_rd = 1'b0;
    run(2);
    check("c_head44", 32'(data_out), 32'h44);
    run(4);
    check("c_full_head44", 32'(data_out), 32'h44);
    run(3);
    data_rd = 1'b1;
    run(1);
    check("c_head55", 32'(data_out), 32'h55);
    run(1);
    check("c_head66", 32'(data_out), 32'h66);
    check("c_ovf_sticky", 32'(overflow), 32'd1);
    data_rd = 1'b0;

    // Retrain with full FIFO and a coinciding pop
    run(12);
    check("f_full", 32'(data_vld), 32'd1);
    train_req = 1'b1; data_rd = 1'b1;
    step();
    train_req = 1'b0; data_rd = 1'b0;
    check("f_vld", 32'(data_vld), 32'd0);
    check("f_ovf", 32'(overflow), 32'd0);
    check("f_locked", 32'(locked), 32'd0);
    check("f_state", 32'(state_dbg), 32'd1);

    // Stream of five words with data_rd held, then reset mid-word
    train_pulse();
    for (int i = 0; i < 4; i++) push_word(PAT);
    for (int i = 1; i <= 5; i++) push_word(W'(i));
    data_rd = 1'b1;
    run(17);
    check("g_locked", 32'(locked), 32'd1);
    run(22);
`ifdef DDR_RX_DESER_STATS_EN
    check("g_word_cnt", 32'(word_cnt), 32'd5);
`endif
    run(2);
    rst = 1'b1; train_req = 1'b1;
    step();
    rst = 1'b0; train_req = 1'b0;
    tx_q.delete();
    check("g_rst_locked", 32'(locked), 32'd0);
    check("g_rst_vld", 32'(data_vld), 32'd0);
    check("g_rst_out", 32'(data_out), 32'd0);
    check("g_rst_ovf", 32'(overflow), 32'd0);
    check("g_rst_state", 32'(state_dbg), 32'd0);
`ifdef DDR_RX_DESER_STATS_EN
    check("g_rst_word_cnt", 32'(word_cnt), 32'd0);
`endif

    // Idle ignores data without a train request
    for (int i = 0; i < 6; i++) push_word(PAT);
    run(24);
    check("i_locked", 32'(locked), 32'd0);
    check("i_state", 32'(state_dbg), 32'd0);
    data_rd = 1'b0;
    run(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr_rx_deser_ctrl.md
DDR_RX_DESER_CTRL -- requirements
Module: ddr_rx_deser_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, output word width; even, 4..32.
REQ-002 SHALL have parameter TRAIN_PATTERN, default 8'hA5, DATA_WIDTH-bit alignment word.
REQ-003 SHALL have parameter LOCK_COUNT, default 4, consecutive aligned pattern hits required to lock; range 1..15.
REQ-004 SHALL have port clk, input, 1 bit: single clock, all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port ddr_in, input, 2 bits: DDR register output; [1] is the rising-edge sample (older), [0] is the falling-edge sample (newer).
REQ-007 SHALL have port train_req, input, 1 bit: one-cycle pulse that starts or restarts alignment.
REQ-008 SHALL have port locked, output, 1 bit: high in the LOCKED state.
REQ-009 SHALL have ports data_out (output, DATA_WIDTH bits), data_vld (output, 1 bit) and data_rd (input, 1 bit): output word handshake.
REQ-010 SHALL have port overflow, output, 1 bit: sticky flag, set when a word is dropped.

Function
REQ-011 SHALL shift a 2*DATA_WIDTH-bit register (sr) every cycle: sr <= {sr[2W-3:0], ddr_in[1], ddr_in[0]}, with the newest bit at the LSB.
REQ-012 SHALL define candidate words W0 = sr[W-1:0] (offset 0) and W1 = sr[W:1] (offset 1); the MSB is the oldest bit.
REQ-013 SHALL implement states IDLE, TRAIN and LOCKED, with reset state IDLE.
REQ-014 IDLE SHALL go to TRAIN on train_req; data is ignored in IDLE.
REQ-015 TRAIN search: on the first cycle W0 or W1 equals TRAIN_PATTERN, it SHALL latch the offset (W0 wins if both match), set hit_cnt=1 and reset the phase counter (0..W/2-1).
REQ-016 TRAIN verify: at each later phase wrap (every W/2 cycles), a match at the latched offset SHALL increment hit_cnt; a mismatch SHALL clear hit_cnt and return to search.
REQ-017 SHALL go from TRAIN to LOCKED when hit_cnt reaches LOCK_COUNT; no TRAIN word is ever output.
REQ-018 LOCKED SHALL, at each phase wrap, write the word at the latched offset into a 2-entry output FIFO.
REQ-019 data_vld SHALL be high whenever the FIFO is non-empty; data_out SHALL equal the head entry; a transfer occurs on a cycle with data_vld & data_rd.
REQ-020 Latency: the word whose last bit pair is on ddr_in in cycle N SHALL be presented with data_vld in cycle N+2 when the FIFO is empty.
REQ-021 FIFO full with a write due: the write SHALL proceed if data_rd pops in the same cycle; otherwise the new word is dropped and overflow is set.
REQ-022 overflow SHALL clear only on rst or train_req.
REQ-023 train_req in TRAIN or LOCKED SHALL flush the FIFO, clear hit_cnt and overflow, and enter TRAIN on the next cycle.
REQ-024 A train_req coinciding with a FIFO write or pop SHALL win: the FIFO ends up empty.
REQ-025 data_out SHALL hold stable while data_vld=1 and data_rd=0.

Reset
REQ-026 rst SHALL force: state=IDLE, sr=0, phase=0, hit_cnt=0, offset=0, FIFO empty.
REQ-027 Output values during rst: locked=0, data_vld=0, data_out=0, overflow=0.
REQ-028 rst SHALL override train_req and any handshake in the same cycle, including reset asserted mid-word in LOCKED.

Configuration
REQ-029 With macro DDR_RX_DESER_STATS_EN defined, SHALL add output word_cnt (16 bits) counting accepted transfers, saturating at 16'hFFFF and cleared by rst or train_req.
REQ-030 Without DDR_RX_DESER_STATS_EN, port word_cnt and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-031 W=8, LOCK_COUNT=4: train_req, then a stream of 8'hA5 bits at offset 0 -> locked rises 1 cycle after the 4th hit; data_vld stays 0 during training.
REQ-032 Same stream shifted by one bit (offset 1) -> locks at offset 1; a following 8'h3C is output as data_out=8'h3C.
REQ-033 During verify, corrupt the 3rd pattern to 8'hA4 -> hit_cnt clears, locked stays 0; a fresh 4 clean hits then lock.
REQ-034 Locked, data_rd=0, send 8'h11, 8'h22, 8'h33 -> FIFO holds 11 and 22, overflow=1; then data_rd=1 -> outputs 8'h11 then 8'h22.
REQ-035 Locked with FIFO full, assert train_req -> next cycle data_vld=0, overflow=0, locked=0, state TRAIN.
REQ-036 STATS_EN build: 5 accepted transfers -> word_cnt=5; assert rst mid-word -> word_cnt=0 and all outputs at reset values.
